// File: rtl/dft_pkg.sv
// Shared types and index helpers for the radix-2 DIT stage scheduler.
// Defining DFT_BITREV_LOAD_EN adds the S_LOAD state used by the bit-reversed load pass.
package dft_pkg;

    localparam int DFT_STAGE_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP_WAIT,
        S_FLUSH,
        S_DONE
`ifdef DFT_BITREV_LOAD_EN
        , S_LOAD
`endif
    } sched_state_t;

    // Twiddle index for butterfly position pos within a group of stage s.
    function automatic logic [15:0] tw_addr_f(input logic [DFT_STAGE_W-1:0] s,
                                              input logic [15:0] pos,
                                              input int n_log2);
        return pos << (n_log2 - 1 - int'(s));
    endfunction

    function automatic logic [15:0] bitrev_f(input logic [15:0] k, input int n_log2);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n_log2; i++) r[i] = k[n_log2 - 1 - i];
        return r;
    endfunction

endpackage

// File: rtl/dft_issue_pipe.sv
// Registers issue-time butterfly indices and stage so they line up with the
// one-cycle twiddle RAM read.
module dft_issue_pipe
    import dft_pkg::*;
#(
    parameter int N_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld_p0,
    input  logic [N_LOG2-1:0]      top_p0,
    input  logic [N_LOG2-1:0]      bot_p0,
    input  logic [DFT_STAGE_W-1:0] stage_p0,
    output logic                   vld_p1,
    output logic [N_LOG2-1:0]      top_p1,
    output logic [N_LOG2-1:0]      bot_p1,
    output logic [DFT_STAGE_W-1:0] stage_p1
);

    // p0 -> p1: indices only advance when a butterfly actually issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            top_p1   <= '0;
            bot_p1   <= '0;
            stage_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                top_p1   <= top_p0;
                bot_p1   <= bot_p0;
                stage_p1 <= stage_p0;
            end
        end
    end

endmodule

// File: rtl/dft_stage_sched.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT DFT.
// Optional feature macro: DFT_BITREV_LOAD_EN (bit-reversed LOAD pass before RUN).
module dft_stage_sched
    import dft_pkg::*;
#(
    parameter int N_LOG2 = 3,
    parameter int GAP    = 2
) (
    input  logic                                     i_CLK,
    input  logic                                     i_RESET,
    input  logic                                     i_start,
    input  logic                                     i_stall,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_tw_rden,
    output logic [((N_LOG2 > 1) ? N_LOG2 - 2 : 0):0] o_tw_addr,
    output logic                                     o_bf_valid,
    output logic [N_LOG2-1:0]                        o_bf_top,
    output logic [N_LOG2-1:0]                        o_bf_bot,
    output logic [DFT_STAGE_W-1:0]                   o_stage
`ifdef DFT_BITREV_LOAD_EN
    ,
    output logic                                     o_ld_valid,
    output logic [N_LOG2-1:0]                        o_ld_addr,
    output logic [N_LOG2-1:0]                        o_ld_rev
`endif
);

    localparam int BW = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
    localparam logic [BW-1:0]          B_ONE  = BW'(1);
    localparam logic [BW-1:0]          B_LAST = BW'((1 << (N_LOG2 - 1)) - 1);
    localparam logic [DFT_STAGE_W-1:0] S_ONE  = DFT_STAGE_W'(1);
    localparam logic [DFT_STAGE_W-1:0] S_LAST = DFT_STAGE_W'(N_LOG2 - 1);
    localparam logic [3:0]             G_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    sched_state_t           state;
    logic [DFT_STAGE_W-1:0] s;
    logic [BW-1:0]          b;
    logic [3:0]             g;

    logic [N_LOG2-1:0] half_p0, pos_p0, grp_p0, top_p0, bot_p0;
    logic              vld_p0;

`ifdef DFT_BITREV_LOAD_EN
    localparam logic [N_LOG2-1:0] K_ONE  = N_LOG2'(1);
    localparam logic [N_LOG2-1:0] K_LAST = '1;
    logic [N_LOG2-1:0] k;
`endif

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state <= S_IDLE;
            s     <= '0;
            b     <= '0;
            g     <= '0;
`ifdef DFT_BITREV_LOAD_EN
            k     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        s <= '0;
                        b <= '0;
                        g <= '0;
`ifdef DFT_BITREV_LOAD_EN
                        k     <= '0;
                        state <= S_LOAD;
`else
                        state <= S_RUN;
`endif
                    end
                end
`ifdef DFT_BITREV_LOAD_EN
                S_LOAD: begin
                    if (!i_stall) begin
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= S_RUN;
                        end else begin
                            k <= k + K_ONE;
                        end
                    end
                end
`endif
                S_RUN: begin
                    // A stall freezes the stage-end decision as well as the issue
                    if (!i_stall) begin
                        if (b == B_LAST) begin
                            b <= '0;
                            if (s == S_LAST) begin
                                state <= S_FLUSH;
                            end else begin
                                s     <= s + S_ONE;
                                state <= (GAP == 0) ? S_RUN : S_GAP_WAIT;
                            end
                        end else begin
                            b <= b + B_ONE;
                        end
                    end
                end
                S_GAP_WAIT: begin
                    if (g == G_LAST) begin
                        g     <= '0;
                        state <= S_RUN;
                    end else begin
                        g <= g + 4'd1;
                    end
                end
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Issue stage (p0): indices of butterfly (s,b)
    always_comb begin
        half_p0 = N_LOG2'(1) << s;
        pos_p0  = N_LOG2'(b) & (half_p0 - N_LOG2'(1));
        grp_p0  = N_LOG2'(b) >> s;
        top_p0  = (grp_p0 << (s + S_ONE)) | pos_p0;
        bot_p0  = top_p0 + half_p0;
    end

    assign vld_p0    = (state == S_RUN) && !i_stall;
    assign o_tw_rden = vld_p0;
    assign o_tw_addr = BW'(tw_addr_f(s, 16'(pos_p0), N_LOG2));
    assign o_busy    = (state != S_IDLE);
    assign o_done    = (state == S_DONE);

`ifdef DFT_BITREV_LOAD_EN
    assign o_ld_valid = (state == S_LOAD) && !i_stall;
    assign o_ld_addr  = k;
    assign o_ld_rev   = N_LOG2'(bitrev_f(16'(k), N_LOG2));
`endif

    dft_issue_pipe #(.N_LOG2(N_LOG2)) u_issue (
        .clk      (i_CLK),
        .rst_n    (i_RESET),
        .vld_p0   (vld_p0),
        .top_p0   (top_p0),
        .bot_p0   (bot_p0),
        .stage_p0 (s),
        .vld_p1   (o_bf_valid),
        .top_p1   (o_bf_top),
        .bot_p1   (o_bf_bot),
        .stage_p1 (o_stage)
    );

endmodule

// File: tb/tb_dft_stage_sched.sv
// Directed bench for dft_stage_sched (N=8, GAP=2, plus a GAP=0 instance).
// Honours DFT_BITREV_LOAD_EN by shifting all expected cycles by the LOAD pass.
module tb_dft_stage_sched;

`ifdef DFT_BITREV_LOAD_EN
    localparam int OFS = 8;
`else
    localparam int OFS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;

    logic       busy, done, tw_rden, bf_valid;
    logic [1:0] tw_addr;
    logic [2:0] bf_top, bf_bot;
    logic [3:0] stage;

    logic       busy0, done0, tw_rden0, bf_valid0;
    logic [1:0] tw_addr0;
    logic [2:0] bf_top0, bf_bot0;
    logic [3:0] stage0;

`ifdef DFT_BITREV_LOAD_EN
    logic       ld_valid, ld_valid0;
    logic [2:0] ld_addr, ld_rev, ld_addr0, ld_rev0;
`endif

    dft_stage_sched #(.N_LOG2(3), .GAP(2)) u_dut (
        .i_CLK(clk), .i_RESET(rst_n), .i_start(start), .i_stall(stall),
        .o_busy(busy), .o_done(done), .o_tw_rden(tw_rden), .o_tw_addr(tw_addr),
        .o_bf_valid(bf_valid), .o_bf_top(bf_top), .o_bf_bot(bf_bot), .o_stage(stage)
`ifdef DFT_BITREV_LOAD_EN
        , .o_ld_valid(ld_valid), .o_ld_addr(ld_addr), .o_ld_rev(ld_rev)
`endif
    );

    dft_stage_sched #(.N_LOG2(3), .GAP(0)) u_dut_g0 (
        .i_CLK(clk), .i_RESET(rst_n), .i_start(start), .i_stall(stall),
        .o_busy(busy0), .o_done(done0), .o_tw_rden(tw_rden0), .o_tw_addr(tw_addr0),
        .o_bf_valid(bf_valid0), .o_bf_top(bf_top0), .o_bf_bot(bf_bot0), .o_stage(stage0)
`ifdef DFT_BITREV_LOAD_EN
        , .o_ld_valid(ld_valid0), .o_ld_addr(ld_addr0), .o_ld_rev(ld_rev0)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] rden_m, done_m, busy_m, vld_m, done0_m;
    logic [1:0]  tw_q[$];
    logic [9:0]  bf_q[$];
    logic [2:0]  ld_q[$];

    int exp_top[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_bot[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_tw[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int exp_rev[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit_at(input int c);
        return 64'd1 << c;
    endfunction

    // start_mode: 0 = pulse at cycle 0, 1 = held high, 2 = never
    task automatic run_cycles(input int ncyc, input int stall_lo, input int stall_hi,
                              input int start_mode);
        rden_m = '0; done_m = '0; busy_m = '0; vld_m = '0; done0_m = '0;
        tw_q.delete(); bf_q.delete(); ld_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start = (start_mode == 1) || (start_mode == 0 && c == 0);
            stall = (c >= stall_lo) && (c <= stall_hi);
            @(negedge clk);
            rden_m[c]  = tw_rden;
            done_m[c]  = done;
            busy_m[c]  = busy;
            vld_m[c]   = bf_valid;
            done0_m[c] = done0;
            if (tw_rden)  tw_q.push_back(tw_addr);
            if (bf_valid) bf_q.push_back({stage, bf_top, bf_bot});
`ifdef DFT_BITREV_LOAD_EN
            if (ld_valid) ld_q.push_back(ld_rev);
`endif
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic check_issue(input string tag);
        check_eq({tag, "_ntw"}, 64'(tw_q.size()), 64'd12);
        check_eq({tag, "_nbf"}, 64'(bf_q.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < tw_q.size() && i < bf_q.size())
                check_eq($sformatf("%s_bf%0d", tag, i), {52'd0, bf_q[i], tw_q[i]},
                         {52'd0, 4'(i / 4), 3'(exp_top[i]), 3'(exp_bot[i]), 2'(exp_tw[i])});
        end
    endtask

    initial begin
        // Reset held: every output low
        repeat (3) @(negedge clk);
        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_done",  64'(done), 64'd0);
        check_eq("rst_rden",  64'(tw_rden), 64'd0);
        check_eq("rst_addr",  64'(tw_addr), 64'd0);
        check_eq("rst_valid", 64'(bf_valid), 64'd0);
        check_eq("rst_top",   64'(bf_top), 64'd0);
        check_eq("rst_bot",   64'(bf_bot), 64'd0);
        check_eq("rst_stage", 64'(stage), 64'd0);
`ifdef DFT_BITREV_LOAD_EN
        check_eq("rst_ld", {61'd0, ld_valid, ld_addr != 3'd0, ld_rev != 3'd0}, 64'd0);
`endif
        rst_n = 1'b1;

        // Nominal run
        run_cycles(22 + OFS, -1, -1, 0);
        check_eq("nom_rden", rden_m, (span(1, 4) | span(7, 10) | span(13, 16)) << OFS);
        check_eq("nom_done", done_m, bit_at(18 + OFS));
        check_eq("nom_busy", busy_m, span(1, 18 + OFS));
        check_eq("nom_valid", vld_m, (span(1, 4) | span(7, 10) | span(13, 16)) << (OFS + 1));
        check_eq("gap0_done", done0_m, bit_at(14 + OFS));
        check_issue("nom");
`ifdef DFT_BITREV_LOAD_EN
        check_eq("ld_n", 64'(ld_q.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < ld_q.size()) check_eq($sformatf("ld_rev%0d", i), 64'(ld_q[i]), 64'(exp_rev[i]));
`endif

        // Stall for three cycles on stage 1, b=2
        run_cycles(25 + OFS, 9 + OFS, 11 + OFS, 0);
        check_eq("stl_rden", rden_m,
                 (span(1, 4) | span(7, 8) | span(12, 13) | span(16, 19)) << OFS);
        check_eq("stl_done", done_m, bit_at(21 + OFS));
        check_issue("stl");

        // Asynchronous reset in the middle of stage 1
        run_cycles(9 + OFS, -1, -1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("ares_rden",  64'(tw_rden), 64'd0);
        check_eq("ares_busy",  64'(busy), 64'd0);
        check_eq("ares_valid", 64'(bf_valid), 64'd0);
        check_eq("ares_top",   64'(bf_top), 64'd0);
        check_eq("ares_stage", 64'(stage), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cycles(30, -1, -1, 2);
        check_eq("ares_nodone", done_m, 64'd0);
        check_eq("ares_idle", busy_m, 64'd0);
        run_cycles(22 + OFS, -1, -1, 0);
        check_eq("ares_done", done_m, bit_at(18 + OFS));
        check_issue("ares");

        // Start held high: second run accepted the cycle busy falls
        run_cycles(2 * (19 + OFS) + 2, -1, -1, 1);
        check_eq("rtg_done", done_m, bit_at(18 + OFS) | bit_at(37 + 2 * OFS));
        check_eq("rtg_busy_gap", 64'(busy_m[19 + OFS]), 64'd0);
        check_eq("rtg_busy_back", 64'(busy_m[20 + OFS]), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
